// File: rtl/shift_sequencer.sv
// Command-driven controller for an 8-bit bidirectional shift register.
// Loads a word, shifts it N times, returns the result over valid/ready.
module shift_sequencer #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_shift_left,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             sr_enable,
  output logic             sr_load,
  output logic             sr_shift_left,
  output logic [WIDTH-1:0] sr_datain,
  input  logic [WIDTH-1:0] sr_dataout
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] count_clamped;
  logic             accept;

  assign count_clamped = (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
  assign accept        = cmd_valid & cmd_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_n = LOAD;
      LOAD:    state_n = (rem == '0) ? DONE : SHIFT;
      SHIFT:   if (rem == CNT_W'(1)) state_n = DONE;
      DONE:    if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // abort outranks both command accept and result handshake
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      data_q <= '0;
      dir_q  <= 1'b0;
      rem    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        data_q <= cmd_data;
        dir_q  <= cmd_shift_left;
        rem    <= count_clamped;
      end else if (state == SHIFT && rem != '0) begin
        rem <= rem - CNT_W'(1);
      end
    end
  end

  // Control pins decode from registered state only
  assign sr_enable     = (state == LOAD) | (state == SHIFT);
  assign sr_load       = (state == LOAD);
  assign sr_shift_left = dir_q;
  assign sr_datain     = (state == LOAD) ? data_q : '0;

  assign res_valid = (state == DONE);
  assign res_data  = (state == DONE) ? sr_dataout : '0;
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE) & ~abort;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer paired with a shift-register model.
// Directed vectors; monitor checks results, latency and control timing.
module tb_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       abort;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_shift_left;
  logic [3:0] cmd_count;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;
  logic       sr_enable;
  logic       sr_load;
  logic       sr_shift_left;
  logic [7:0] sr_datain;
  logic [7:0] sr_dataout;
  logic [7:0] sr_q;

  int nasserts = 0;
  int nfail = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       dir;
    int         nshift;
    int         lat;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  shift_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .abort          (abort),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .cmd_shift_left (cmd_shift_left),
    .cmd_count      (cmd_count),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .busy           (busy),
    .sr_enable      (sr_enable),
    .sr_load        (sr_load),
    .sr_shift_left  (sr_shift_left),
    .sr_datain      (sr_datain),
    .sr_dataout     (sr_dataout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Shift register model: load wins, zero fill on shifts
  always @(posedge clock or negedge reset) begin
    if (!reset) sr_q <= 8'h00;
    else if (sr_enable) begin
      if (sr_load) sr_q <= sr_datain;
      else if (sr_shift_left) sr_q <= {sr_q[6:0], 1'b0};
      else sr_q <= {1'b0, sr_q[7:1]};
    end
  end
  assign sr_dataout = sr_q;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nasserts++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    bit prev_valid = 1'b0;
    int load_cnt = 0;
    int shift_cnt = 0;
    int dir_err = 0;
    forever begin
      @(negedge clock);
      if (!reset || !busy) begin
        load_cnt = 0;
        shift_cnt = 0;
        dir_err = 0;
      end
      if (reset) begin
        if (sr_enable && sr_load) load_cnt++;
        else if (sr_enable) begin
          shift_cnt++;
          if (sb.size() > 0 && sr_shift_left !== sb[0].dir) dir_err++;
        end
        if (res_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_res_valid", res_valid, 0);
          end else begin
            if (!prev_valid) begin
              check("latency", cyc - sb[0].cyc, sb[0].lat);
              check("load_cycles", load_cnt, 1);
              check("shift_cycles", shift_cnt, sb[0].nshift);
              check("shift_dir", dir_err, 0);
            end
            check("res_data", res_data, sb[0].data);
            check("done_sr_enable", sr_enable, 0);
            check("done_cmd_ready", cmd_ready, 0);
            if (res_ready) void'(sb.pop_front());
          end
        end
      end
      prev_valid = reset && res_valid;
    end
  end

  task automatic send(input logic [7:0] d, input logic dir,
                      input logic [3:0] cnt, input logic [7:0] exp,
                      input bit track);
    int n = 0;
    exp_t e;
    @(posedge clock);
    #2;
    cmd_valid = 1'b1;
    cmd_data = d;
    cmd_shift_left = dir;
    cmd_count = cnt;
    @(negedge clock);
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", cmd_ready, 1);
    end else if (track) begin
      e.data = exp;
      e.dir = dir;
      e.nshift = (cnt > 4'd8) ? 8 : int'(cnt);
      e.lat = e.nshift + 2;
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clock);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clock);
    while ((busy || sb.size() != 0) && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("done_timeout_busy", busy, 0);
    check("done_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    abort = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    cmd_shift_left = 1'b0;
    cmd_count = 4'd0;
    res_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_sr_enable", sr_enable, 0);
    check("rst_sr_load", sr_load, 0);
    check("rst_sr_datain", sr_datain, 0);
    check("rst_sr_shift_left", sr_shift_left, 0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_cmd_ready", cmd_ready, 1);

    send(8'b10110110, 1'b0, 4'd4, 8'b00001011, 1'b1);
    wait_done();
    send(8'b10110110, 1'b1, 4'd3, 8'b10110000, 1'b1);
    wait_done();
    send(8'hA5, 1'b0, 4'd0, 8'hA5, 1'b1);
    wait_done();
    send(8'hFF, 1'b1, 4'd15, 8'h00, 1'b1);
    wait_done();

    // Back-pressure on the result
    @(posedge clock);
    #2;
    res_ready = 1'b0;
    send(8'h3C, 1'b0, 4'd2, 8'h0F, 1'b1);
    n = 0;
    while (!res_valid && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("bp_res_valid_seen", res_valid, 1);
    repeat (5) @(negedge clock);
    check("bp_still_valid", res_valid, 1);
    @(posedge clock);
    #2;
    res_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_idle_after_hs", busy, 0);
    check("bp_sb_empty", sb.size(), 0);

    // Abort beats a command in IDLE
    @(posedge clock);
    #2;
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = 8'h55;
    cmd_count = 4'd1;
    @(negedge clock);
    check("abort_idle_cmd_ready", cmd_ready, 0);
    @(posedge clock);
    #2;
    abort = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clock);
    check("abort_idle_busy", busy, 0);

    // Abort in the second SHIFT cycle
    send(8'h81, 1'b1, 4'd5, 8'h00, 1'b0);
    @(posedge clock);
    #2;
    @(posedge clock);
    #2;
    abort = 1'b1;
    @(negedge clock);
    check("abort_shift_enable", sr_enable, 1);
    check("abort_shift_load", sr_load, 0);
    @(posedge clock);
    #2;
    abort = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_sr_enable", sr_enable, 0);
    repeat (12) @(negedge clock);
    check("abort_no_res", res_valid, 0);

    // Asynchronous reset mid-SHIFT
    send(8'h81, 1'b1, 4'd6, 8'h00, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_sr_enable", sr_enable, 0);
    check("mid_rst_sr_load", sr_load, 0);
    check("mid_rst_sr_datain", sr_datain, 0);
    check("mid_rst_sr_shift_left", sr_shift_left, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    send(8'h81, 1'b0, 4'd1, 8'h40, 1'b1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasserts, nfail);
    $finish;
  end

endmodule
